// File: rtl/serial_word_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_deser
// Purpose  : MSB-first serial-to-word deserializer with a one-word valid/ready
//            holding register and sticky overrun flag.
//            Optional even-parity trailer bit: SERIAL_WORD_DESER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_deser #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun
`ifdef SERIAL_WORD_DESER_PARITY_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int c_CNT_W = $clog2(WIDTH+1);
`ifdef SERIAL_WORD_DESER_PARITY_EN
    localparam int                 c_SH_W = WIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH);
`else
    // The newest bit joins the word straight from bit_in, so only WIDTH-1 bits are stored.
    localparam int                 c_SH_W = WIDTH - 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
`endif

    logic [c_SH_W-1:0]  r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_overrun;
    logic [WIDTH-1:0]   w_cand;
    logic               w_complete;
    logic               w_free;
`ifdef SERIAL_WORD_DESER_PARITY_EN
    logic               r_perr;
    logic               w_perr;
`endif

    always_comb begin
        w_complete = bit_valid && (r_cnt == c_LAST);
        w_free     = !r_valid || out_ready;
`ifdef SERIAL_WORD_DESER_PARITY_EN
        w_cand     = r_shreg;
        w_perr     = ^{r_shreg, bit_in};
`else
        w_cand     = {r_shreg, bit_in};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef SERIAL_WORD_DESER_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            if (bit_valid) begin
                r_cnt <= w_complete ? '0 : r_cnt + c_CNT_W'(1);
`ifdef SERIAL_WORD_DESER_PARITY_EN
                if (!w_complete) begin
                    r_shreg <= {r_shreg[WIDTH-2:0], bit_in};
                end
`else
                r_shreg <= w_cand[WIDTH-2:0];
`endif
            end

            if (w_complete && w_free) begin
                r_data  <= w_cand;
                r_valid <= 1'b1;
`ifdef SERIAL_WORD_DESER_PARITY_EN
                r_perr  <= w_perr;
`endif
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end

            // A finished word with nowhere to go is dropped and flagged until reset.
            if (w_complete && !w_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign bit_cnt   = r_cnt;
    assign overrun   = r_overrun;
`ifdef SERIAL_WORD_DESER_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_word_deser.sv
`default_nettype none
// Self-checking bench for serial_word_deser: directed scenarios plus randomized
// traffic compared against a frame-level reference model.
module tb_serial_word_deser;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH+1);
`ifdef SERIAL_WORD_DESER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             bit_in    = 1'b0;
    logic             bit_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
`ifdef SERIAL_WORD_DESER_PARITY_EN
    logic             parity_err;
`endif

    serial_word_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
`ifdef SERIAL_WORD_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits collected since the last frame boundary plus the holding register.
    int               m_cnt   = 0;
    logic [WIDTH:0]   m_part  = '0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;
    logic             m_ovr   = 1'b0;
`ifdef SERIAL_WORD_DESER_PARITY_EN
    logic             m_perr  = 1'b0;
`endif

    // Bits of one frame, sent from index NB-1 down to 0; pflip corrupts the parity bit.
    function automatic logic [WIDTH:0] frame(input logic [WIDTH-1:0] w, input logic pflip);
`ifdef SERIAL_WORD_DESER_PARITY_EN
        return {w, (^w) ^ pflip};
`else
        return {pflip, w};
`endif
    endfunction

    task automatic tick(input logic b, input logic v, input logic r);
        logic             done;
        logic [WIDTH-1:0] word;
        bit_in    = b;
        bit_valid = v;
        out_ready = r;
        @(posedge clk);
        done = 1'b0;
        word = '0;
        if (reset) begin
            m_cnt = 0; m_part = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
`ifdef SERIAL_WORD_DESER_PARITY_EN
            m_perr = 1'b0;
`endif
        end else begin
            if (v) begin
                m_part = {m_part[WIDTH-1:0], b};
                m_cnt++;
                if (m_cnt == NB) begin
                    done  = 1'b1;
                    m_cnt = 0;
`ifdef SERIAL_WORD_DESER_PARITY_EN
                    word  = m_part[WIDTH:1];
`else
                    word  = m_part[WIDTH-1:0];
`endif
                end
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_data  = word;
                    m_valid = 1'b1;
`ifdef SERIAL_WORD_DESER_PARITY_EN
                    m_perr  = ^m_part;
`endif
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        reset = 1'b0;
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (bit_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic_word();
        logic [WIDTH:0] f;
        f = frame(8'hB2, 1'b0);
        for (int i = NB - 1; i >= 0; i--) begin
            tick(f[i], 1'b1, 1'b1);
            if (i != 0) begin
                n_vec++; if (bit_cnt !== CW'(NB - i)) begin n_err++; $display("FAIL basic_cnt: got %0d want %0d", bit_cnt, NB - i); end
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
            end
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hB2) begin n_err++; $display("FAIL basic_data: got %h want b2", out_data); end
        n_vec++; if (bit_cnt !== '0) begin n_err++; $display("FAIL basic_cnt_wrap: got %0d want 0", bit_cnt); end
        tick(1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'hB2) begin n_err++; $display("FAIL basic_data_hold: got %h want b2", out_data); end
    endtask

    task automatic test_gapped();
        logic [WIDTH:0] f;
        f = frame(8'hB2, 1'b0);
        for (int k = 1; k <= NB; k++) begin
            tick(f[NB-k], 1'b1, 1'b1);
            if (k == 4) begin
                for (int g = 0; g < 3; g++) begin
                    tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                    n_vec++; if (bit_cnt !== CW'(4)) begin n_err++; $display("FAIL gap_cnt_hold: got %0d want 4", bit_cnt); end
                end
            end
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hB2) begin n_err++; $display("FAIL gap_data: got %h want b2", out_data); end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure_overrun();
        logic [WIDTH:0] f;
        f = frame(8'hB2, 1'b0);
        for (int i = NB - 1; i >= 0; i--) tick(f[i], 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hB2) begin n_err++; $display("FAIL bp_first: got %b/%h want 1/b2", out_valid, out_data); end
        f = frame(8'h5A, 1'b0);
        for (int i = NB - 1; i >= 0; i--) begin
            tick(f[i], 1'b1, 1'b0);
            n_vec++; if (out_data !== 8'hB2) begin n_err++; $display("FAIL bp_stable: got %h want b2", out_data); end
            n_vec++; if (overrun !== (i == 0)) begin n_err++; $display("FAIL bp_overrun: got %b want %b", overrun, i == 0); end
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b want 1", out_valid); end
        tick(1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %b want 1", overrun); end
        tick(1'b0, 1'b0, 1'b1);
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_sticky2: got %b want 1", overrun); end
    endtask

    task automatic test_reset_midword();
        logic [WIDTH:0] f;
        int pulses;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        n_vec++; if (bit_cnt !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL midrst_clear: got cnt=%0d v=%b ovr=%b want 0/0/0", bit_cnt, out_valid, overrun);
        end
        f = frame(8'hFF, 1'b0);
        pulses = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            tick(f[i], 1'b1, 1'b1);
            if (out_valid) pulses++;
        end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL midrst_data: got %h want ff", out_data); end
        tick(1'b0, 1'b0, 1'b1);
        if (out_valid) pulses++;
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w;
        logic [WIDTH:0]   f;
        for (int n = 0; n < 5; n++) begin
            w = WIDTH'($urandom);
            f = frame(w, 1'b0);
            for (int i = NB - 1; i >= 0; i--) tick(f[i], 1'b1, 1'b1);
            n_vec++; if (out_valid !== 1'b1 || out_data !== w) begin
                n_err++; $display("FAIL b2b_word%0d: got %b/%h want 1/%h", n, out_valid, out_data, w);
            end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

`ifdef SERIAL_WORD_DESER_PARITY_EN
    task automatic test_parity();
        logic [WIDTH:0] f;
        for (int p = 0; p < 2; p++) begin
            f = frame(8'hB2, 1'(p));
            for (int i = NB - 1; i >= 0; i--) tick(f[i], 1'b1, 1'b1);
            n_vec++; if (out_data !== 8'hB2) begin n_err++; $display("FAIL parity_data%0d: got %h want b2", p, out_data); end
            n_vec++; if (parity_err !== 1'(p)) begin n_err++; $display("FAIL parity_err%0d: got %b want %0d", p, parity_err, p); end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        int ready_pct;
        ready_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) ready_pct = $urandom_range(5, 100);
            reset = ($urandom_range(0, 299) == 0);
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(1, 100) <= ready_pct));
            reset = 1'b0;
            n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, m_valid); end
            n_vec++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data @%0d: got %h want %h", c, out_data, m_data); end
            n_vec++; if (bit_cnt !== CW'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", c, bit_cnt, m_cnt); end
            n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rnd_overrun @%0d: got %b want %b", c, overrun, m_ovr); end
`ifdef SERIAL_WORD_DESER_PARITY_EN
            if (m_valid) begin
                n_vec++; if (parity_err !== m_perr) begin n_err++; $display("FAIL rnd_perr @%0d: got %b want %b", c, parity_err, m_perr); end
            end
`endif
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_word();
        test_gapped();
        test_backpressure_overrun();
        test_reset_midword();
        test_back_to_back();
`ifdef SERIAL_WORD_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
